// File: rtl/gate_timing_monitor.sv
// Receive-side checker: measures Sync/Gate/Done phase widths and emits one record per frame.
// Record valid one cycle after done is sampled; no backpressure, the monitor only observes.
module gate_timing_monitor #(
  parameter int SYNC_W = 8,
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              sync_in,
  input  logic              gate_in,
  input  logic              done_in,
  output logic [SYNC_W-1:0] m_sync,
  output logic [SYNC_W-1:0] m_gdel,
  output logic [GATE_W-1:0] m_gate,
  output logic [GATE_W-1:0] m_len,
  output logic              valid,
  output logic              ovf,
  output logic              err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SYNC, GDEL, GATE, LEN} state_t;

  localparam logic [SYNC_W-1:0] SYNC_ONE = {{(SYNC_W-1){1'b0}}, 1'b1};
  localparam logic [GATE_W-1:0] GATE_ONE = {{(GATE_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [SYNC_W-1:0] sync_cnt, gdel_cnt;
  logic [GATE_W-1:0] gate_cnt, len_cnt;
  logic              ovf_acc;
  logic              sync_q;
  logic              frame_err, frame_done;

  // Terminal conditions for the current frame, decided from the state and sampled strobes.
  always_comb begin
    frame_err  = 1'b0;
    frame_done = 1'b0;
    case (state)
      SYNC: frame_err = done_in | (sync_in & gate_in);
      GDEL: frame_err = sync_in | done_in;
      GATE: begin
        frame_err  = sync_in;
        frame_done = !sync_in && !gate_in && done_in;
      end
      LEN: begin
        frame_err  = sync_in | gate_in;
        frame_done = !sync_in && !gate_in && done_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sync_cnt <= '0;
      gdel_cnt <= '0;
      gate_cnt <= '0;
      len_cnt  <= '0;
      ovf_acc  <= 1'b0;
      sync_q   <= 1'b0;
      m_sync   <= '0;
      m_gdel   <= '0;
      m_gate   <= '0;
      m_len    <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sync_q <= sync_in;
      valid  <= 1'b0;
      err    <= 1'b0;
      if (!ena || frame_err || frame_done) begin
        state    <= IDLE;
        busy     <= 1'b0;
        sync_cnt <= '0;
        gdel_cnt <= '0;
        gate_cnt <= '0;
        len_cnt  <= '0;
        ovf_acc  <= 1'b0;
        err      <= ena & frame_err;
        valid    <= ena & frame_done;
        if (ena && frame_done) begin
          m_sync <= sync_cnt;
          m_gdel <= gdel_cnt;
          m_gate <= gate_cnt;
          m_len  <= len_cnt;
          ovf    <= ovf_acc;
        end
      end else begin
        case (state)
          IDLE: begin
            // Only a fresh rising sync starts a frame, so a sync held across an error is ignored.
            if (sync_in && !sync_q && !gate_in && !done_in) begin
              state    <= SYNC;
              busy     <= 1'b1;
              sync_cnt <= SYNC_ONE;
            end
          end
          SYNC: begin
            if (sync_in) begin
              if (&sync_cnt) ovf_acc <= 1'b1;
              else sync_cnt <= sync_cnt + SYNC_ONE;
            end else if (gate_in) begin
              state    <= GATE;
              gdel_cnt <= '0;
              gate_cnt <= GATE_ONE;
            end else begin
              state    <= GDEL;
              gdel_cnt <= SYNC_ONE;
            end
          end
          GDEL: begin
            if (gate_in) begin
              state    <= GATE;
              gate_cnt <= GATE_ONE;
            end else if (&gdel_cnt) ovf_acc <= 1'b1;
            else gdel_cnt <= gdel_cnt + SYNC_ONE;
          end
          GATE: begin
            if (!gate_in) begin
              state   <= LEN;
              len_cnt <= GATE_ONE;
            end else if (&gate_cnt) ovf_acc <= 1'b1;
            else gate_cnt <= gate_cnt + GATE_ONE;
          end
          LEN: begin
            if (&len_cnt) ovf_acc <= 1'b1;
            else len_cnt <= len_cnt + GATE_ONE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
